alu_cmd_driver: RTL

//  Initiator side of the ALU operand/opcode interface. Accepts tagged commands on a

---
 rtl/alu_pkg.sv | 70 +++++++
 rtl/alu_cmd_fifo.sv | 65 ++++++
 rtl/alu_cmd_driver.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU command driver: operating-mode encodings,
//   opcode values for both ALU op sets, packed command field layout, the
//   driver FSM state type and the command legality check.
// ----------------------------------------------------------------------------
package alu_pkg;

  // Operating modes. The mode also selects which ALU enables are raised:
  // A-set -> a_en only, B-set1 -> b_en only, B-set2 -> both.
  localparam logic [1:0] MODE_ILL = 2'b00;
  localparam logic [1:0] MODE_A   = 2'b01;
  localparam logic [1:0] MODE_B1  = 2'b10;
  localparam logic [1:0] MODE_B2  = 2'b11;

  // A-set opcodes (3 bit). 111 has no defined operation.
  localparam logic [2:0] OPA_ADD  = 3'b000;
  localparam logic [2:0] OPA_SUB  = 3'b001;
  localparam logic [2:0] OPA_AND  = 3'b010;
  localparam logic [2:0] OPA_OR   = 3'b011;
  localparam logic [2:0] OPA_XOR  = 3'b100;
  localparam logic [2:0] OPA_XNOR = 3'b101;
  localparam logic [2:0] OPA_SHL  = 3'b110;
  localparam logic [2:0] OPA_ILL  = 3'b111;

  // B-set1 opcodes (2 bit). Codes 10 and 11 have no defined operation.
  localparam logic [1:0] OPB1_NAND = 2'b00;
  localparam logic [1:0] OPB1_NOR  = 2'b01;

  // B-set2 opcodes (2 bit). All four codes are defined.
  localparam logic [1:0] OPB2_INCA = 2'b00;
  localparam logic [1:0] OPB2_INCB = 2'b01;
  localparam logic [1:0] OPB2_DECA = 2'b10;
  localparam logic [1:0] OPB2_DECB = 2'b11;

  // Operand / result widths seen by the ALU.
  localparam int OPND_W = 5;
  localparam int RES_W  = 6;

  // Packed command layout (tag sits above CMD_W): {tag, mode, op, a, b}.
  localparam int CMD_W    = 15;
  localparam int B_LSB    = 0;
  localparam int A_LSB    = 5;
  localparam int OP_LSB   = 10;
  localparam int MODE_LSB = 13;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  // A command is illegal when it would not make the ALU update its result:
  // no mode selected, the unused A-set opcode, or the upper half of the
  // B-set1 opcode space. B-set modes only look at op[1:0].
  function automatic logic is_illegal(input logic [1:0] mode, input logic [2:0] op);
    logic ill;
    ill = 1'b0;
    case (mode)
      MODE_ILL: ill = 1'b1;
      MODE_A:   ill = (op == OPA_ILL);
      MODE_B1:  ill = op[1];
      default:  ill = 1'b0;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ----------------------------------------------------------------------------
// alu_cmd_fifo
//   Generic synchronous FIFO used to queue commands ahead of the driver FSM
//   (usable as a response queue as well). Read data is presented
//   combinationally from the head entry; pop only advances the pointer.
//
//   Parameters : DEPTH (power of 2, >= 2), WIDTH (entry width)
//   Ports      : clk, rst_n (async, active-low)
//                push, push_data  - write request, ignored while full
//                pop, pop_data    - advance head, ignored while empty
//                full, empty      - occupancy flags
// ----------------------------------------------------------------------------
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  // One bit wider than the pointers so DEPTH entries can be represented.
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// ----------------------------------------------------------------------------
// alu_cmd_driver
//   Initiator side of the ALU operand/opcode interface. Tagged commands are
//   accepted on a valid/ready channel and queued. Each legal command is sent
//   to the registered ALU as a single-cycle alu_en pulse; the result is
//   captured the following cycle and returned with its tag on a valid/ready
//   response channel. Illegal commands are answered with rsp_err=1 and never
//   reach the ALU. One ALU operation is outstanding at a time and responses
//   leave in acceptance order.
//
//   Parameters : DEPTH (command queue entries), TAG_W (tag width)
//   Ports      : clk, rst_n (async, active-low)
//                cmd_valid/cmd_ready, cmd_mode, cmd_op, cmd_a, cmd_b, cmd_tag
//                rsp_valid/rsp_ready, rsp_data, rsp_err, rsp_tag
//                alu_a, alu_b, alu_a_en, alu_b_en, alu_a_op, alu_b_op, alu_en
//                alu_c (registered ALU result)
// ----------------------------------------------------------------------------
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // command channel
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_mode,
  input  logic [2:0]               cmd_op,
  input  logic signed [OPND_W-1:0] cmd_a,
  input  logic signed [OPND_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]         cmd_tag,
  // response channel
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic signed [RES_W-1:0]  rsp_data,
  output logic                     rsp_err,
  output logic [TAG_W-1:0]         rsp_tag,
  // ALU interface
  output logic signed [OPND_W-1:0] alu_a,
  output logic signed [OPND_W-1:0] alu_b,
  output logic                     alu_a_en,
  output logic                     alu_b_en,
  output logic [2:0]               alu_a_op,
  output logic [1:0]               alu_b_op,
  output logic                     alu_en,
  input  logic signed [RES_W-1:0]  alu_c
);

  localparam int ENTRY_W = CMD_W + TAG_W;

  state_t                     state;
  state_t                     state_nxt;

  logic [ENTRY_W-1:0]         cmd_entry;
  logic [ENTRY_W-1:0]         fifo_head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       accept;
  logic                       bypass;
  logic                       load_hold;
  logic                       rsp_hs;

  logic [ENTRY_W-1:0]         hold_p0;
  logic [1:0]                 h_mode;
  logic [2:0]                 h_op;
  logic signed [OPND_W-1:0]   h_a;
  logic signed [OPND_W-1:0]   h_b;
  logic [TAG_W-1:0]           h_tag;
  logic                       h_illegal;

  logic signed [RES_W-1:0]    rsp_data_p1;
  logic                       rsp_err_p1;

  assign cmd_entry = {cmd_tag, cmd_mode, cmd_op, cmd_a, cmd_b};
  assign cmd_ready = ~fifo_full;
  assign accept    = cmd_valid & cmd_ready;

  // With the queue empty and the FSM idle, a new command goes straight into
  // the holding register so it decodes on the very next cycle. Only taken
  // when the queue is empty, so ordering is preserved.
  assign bypass    = (state == IDLE) & fifo_empty & accept;
  assign fifo_push = accept & ~bypass;
  assign rsp_hs    = (state == RESP) & rsp_ready;
  assign fifo_pop  = ~fifo_empty & ((state == IDLE) | rsp_hs);
  assign load_hold = fifo_pop | bypass;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (cmd_entry),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---- stage p0: holding register for the command being serviced ----
  always_ff @(posedge clk) begin
    if (load_hold) hold_p0 <= bypass ? cmd_entry : fifo_head;
  end

  assign h_b       = hold_p0[B_LSB +: OPND_W];
  assign h_a       = hold_p0[A_LSB +: OPND_W];
  assign h_op      = hold_p0[OP_LSB +: 3];
  assign h_mode    = hold_p0[MODE_LSB +: 2];
  assign h_tag     = hold_p0[CMD_W +: TAG_W];
  assign h_illegal = is_illegal(h_mode, h_op);

  // ---- stage p1: response payload, set in DECODE (error) or CAPTURE ----
  always_ff @(posedge clk) begin
    if (state == DECODE) begin
      rsp_data_p1 <= '0;
      rsp_err_p1  <= h_illegal;
    end else if (state == CAPTURE) begin
      rsp_data_p1 <= alu_c;
      rsp_err_p1  <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty || accept) state_nxt = DECODE;
      DECODE:  state_nxt = h_illegal ? RESP : ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) state_nxt = fifo_empty ? IDLE : DECODE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. Everything is decoded from the state register so the ALU
  // strobe and enables fall as soon as reset asserts. Response fields are
  // only shown while rsp_valid is high.
  always_comb begin
    alu_en    = 1'b0;
    alu_a_en  = 1'b0;
    alu_b_en  = 1'b0;
    alu_a_op  = '0;
    alu_b_op  = '0;
    alu_a     = '0;
    alu_b     = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    rsp_tag   = '0;
    case (state)
      ISSUE: begin
        alu_en = 1'b1;
        alu_a  = h_a;
        alu_b  = h_b;
        case (h_mode)
          MODE_A: begin
            alu_a_en = 1'b1;
            alu_a_op = h_op;
          end
          MODE_B1: begin
            alu_b_en = 1'b1;
            alu_b_op = h_op[1:0];
          end
          MODE_B2: begin
            alu_a_en = 1'b1;
            alu_b_en = 1'b1;
            alu_b_op = h_op[1:0];
          end
          default: ;
        endcase
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = rsp_data_p1;
        rsp_err   = rsp_err_p1;
        rsp_tag   = h_tag;
      end
      default: ;
    endcase
  end

endmodule
